// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

  // Wait counter width; covers MEM_LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way picker with a last-grant pointer (round-robin) or fixed priority to requester 0.
// Latency: combinational grant; pointer updates on the clock edge where update=1.
// Backpressure: grant is only meaningful when the caller can accept; caller gates it.
module rr_arbiter2 #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant0,
  output logic grant1,
  output logic winner
);

  logic last_q;
  logic last_d;
  logic winner_c;

  // Pick the winner: fixed mode favours req0, round-robin favours the one not served last.
  always_comb begin
    winner_c = 1'b0;
    if (FIXED_PRIORITY != 0) begin
      winner_c = !req0 && req1;
    end else if (req0 && req1) begin
      winner_c = !last_q;
    end else begin
      winner_c = req1;
    end
  end

  assign winner = winner_c;
  assign grant0 = req0 && !winner_c;
  assign grant1 = req1 && winner_c;

  // Pointer follows the winner only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (update) begin
      last_d = winner_c;
    end
  end

  // Pointer register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one fixed-latency single-port memory, one transaction at a time.
// Latency: accept at A, mem_en at A+1, response pulse at A+2+MEM_LATENCY.
// Backpressure: ready only in IDLE for the winner; requests arriving while busy simply wait.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LATENCY    = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                arb_grant0;
  logic                arb_grant1;
  logic                arb_winner;
  logic                accept;

  rr_arbiter2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .update (accept),
    .grant0 (arb_grant0),
    .grant1 (arb_grant1),
    .winner (arb_winner)
  );

  // Sequencer: capture the winner in IDLE, strobe memory, count out the latency, respond.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_grant0 || arb_grant1) begin
          accept  = 1'b1;
          owner_d = arb_winner;
          we_d    = arb_winner ? req1_we    : req0_we;
          addr_d  = arb_winner ? req1_addr  : req0_addr;
          wdata_d = arb_winner ? req1_wdata : req0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = LAT_CNT;
        state_d = WAIT;
      end
      WAIT: begin
        // Treat 0 like 1 so an out-of-range latency cannot wedge the FSM.
        if (cnt_q <= CNT_ONE) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Ready is only offered while idle, and only to the winner.
  assign req0_ready = (state_q == IDLE) && arb_grant0;
  assign req1_ready = (state_q == IDLE) && arb_grant1;

  // Memory strobe decodes straight from state so reset removes it immediately.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Response pulse to the owner only; data forced to 0 outside the pulse.
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : '0;

  assign busy     = (state_q != IDLE);
  assign grant_id = owner_q;

endmodule
